// File: rtl/cdc_in_event_fifo.sv
// ============================================================================
// Module  : cdc_in_event_fifo
// Brief   : Event-byte FIFO feeding the USB CDC IN path; flushes while the
//           device is unconfigured and counts overflow drops.
//           CDC_IN_EVENT_FIFO_OVF_MARK_EN inserts a '!' marker after overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_in_event_fifo #(
    parameter int DEPTH      = 16,
    parameter int DROP_CNT_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [7:0]                 ev_data_i,
    input  logic                       ev_valid_i,
    output logic                       ev_ready_o,
    output logic [7:0]                 in_data_o,
    output logic                       in_valid_o,
    input  logic                       in_ready_i,
    input  logic                       usb_configured_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [DROP_CNT_W-1:0]      drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [7:0] MARK_BYTE = 8'h21;

    logic [7:0]            mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DROP_CNT_W-1:0] drop_cnt;

    logic pop;
    logic room;
    logic push;
    logic drop;
    logic ovf_pending;
    logic mark_write;
    logic wr_en;
    logic [7:0] wr_byte;

    assign pop        = (count != '0) && in_ready_i;
    assign room       = (count < FULL_COUNT) || pop;
    assign ev_ready_o = usb_configured_i && !ovf_pending && room;
    assign push       = ev_valid_i && ev_ready_o;
    assign drop       = ev_valid_i && !ev_ready_o && usb_configured_i;

`ifdef CDC_IN_EVENT_FIFO_OVF_MARK_EN
    // Marker takes the first free slot after a drop; drops during that
    // very cycle are counted but must not start a new episode.
    assign mark_write = usb_configured_i && ovf_pending && room;

    always_ff @(posedge clk_i) begin
        if (rst_i || !usb_configured_i) begin
            ovf_pending <= 1'b0;
        end else if (mark_write) begin
            ovf_pending <= 1'b0;
        end else if (drop) begin
            ovf_pending <= 1'b1;
        end
    end
`else
    assign mark_write  = 1'b0;
    assign ovf_pending = 1'b0;
`endif

    assign wr_en   = push || mark_write;
    assign wr_byte = mark_write ? MARK_BYTE : ev_data_i;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_byte;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !usb_configured_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Drop counter survives unconfiguration; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign in_valid_o = (count != '0);
    assign in_data_o  = mem[rd_ptr];
    assign level_o    = count;
    assign drop_cnt_o = drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cdc_in_event_fifo.sv
// ============================================================================
// Module  : tb_cdc_in_event_fifo
// Brief   : Self-checking bench for cdc_in_event_fifo (DEPTH 16, 8-bit drops).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdc_in_event_fifo;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] ev_data_i;
    logic       ev_valid_i;
    logic       ev_ready_o;
    logic [7:0] in_data_o;
    logic       in_valid_o;
    logic       in_ready_i;
    logic       usb_configured_i;
    logic [4:0] level_o;
    logic [7:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;

    cdc_in_event_fifo #(.DEPTH(16), .DROP_CNT_W(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .ev_data_i        (ev_data_i),
        .ev_valid_i       (ev_valid_i),
        .ev_ready_o       (ev_ready_o),
        .in_data_o        (in_data_o),
        .in_valid_o       (in_valid_o),
        .in_ready_i       (in_ready_i),
        .usb_configured_i (usb_configured_i),
        .level_o          (level_o),
        .drop_cnt_o       (drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cfg;
        logic       ev_valid;
        logic [7:0] ev_data;
        logic       in_ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_level;
        int         exp_drop;
        logic       exp_ev_ready;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ev_valid_i = 1'b0;
        ev_data_i  = 8'h00;
    endtask

    task automatic fill16(input logic [7:0] base);
        in_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ev_valid_i = 1'b1;
            ev_data_i  = base + 8'(i);
            step();
        end
        idle_inputs();
    endtask

    task automatic drop_n(input int n);
        for (int i = 0; i < n; i++) begin
            ev_valid_i = 1'b1;
            ev_data_i  = 8'h99;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        logic [7:0] exp_q [$];
        logic [7:0] b;

        rst_i = 1'b1;
        usb_configured_i = 1'b0;
        in_ready_i = 1'b0;
        idle_inputs();
        step();
        step();
        chk("reset_valid", int'(in_valid_o), 0);
        chk("reset_level", int'(level_o), 0);
        chk("reset_drop", int'(drop_cnt_o), 0);
        chk("reset_ev_ready_uncfg", int'(ev_ready_o), 0);
        rst_i = 1'b0;
        step();

        // {cfg, ev_valid, ev_data, in_ready, exp_valid, exp_data, exp_level, exp_drop, exp_ev_ready}
        vecs[0] = '{1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 0, 0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 8'h61, 1'b1, 1'b1, 8'h41, 1, 0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h61, 1, 0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 0, 0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 0, 1'b1};

        for (int i = 0; i < 6; i++) begin
            usb_configured_i = vecs[i].cfg;
            ev_valid_i       = vecs[i].ev_valid;
            ev_data_i        = vecs[i].ev_data;
            in_ready_i       = vecs[i].in_ready;
            #1;
            chk($sformatf("vec%0d_valid", i), int'(in_valid_o), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_data", i), int'(in_data_o), int'(vecs[i].exp_data));
            chk($sformatf("vec%0d_level", i), int'(level_o), vecs[i].exp_level);
            chk($sformatf("vec%0d_drop", i), int'(drop_cnt_o), vecs[i].exp_drop);
            chk($sformatf("vec%0d_ev_ready", i), int'(ev_ready_o), int'(vecs[i].exp_ev_ready));
            step();
        end
        idle_inputs();
        usb_configured_i = 1'b1;

        // Stall and fill to the full boundary
        fill16(8'h41);
        #1;
        chk("full_level", int'(level_o), 16);
        chk("full_ev_ready_stalled", int'(ev_ready_o), 0);
        chk("full_head", int'(in_data_o), 8'h41);

        // Push and pop together while full
        in_ready_i = 1'b1;
        ev_valid_i = 1'b1;
        ev_data_i  = 8'h51;
        #1;
        chk("full_pushpop_ev_ready", int'(ev_ready_o), 1);
        step();
        idle_inputs();
        in_ready_i = 1'b0;
        #1;
        chk("full_pushpop_level", int'(level_o), 16);
        chk("full_pushpop_drop", int'(drop_cnt_o), 0);
        chk("full_pushpop_head", int'(in_data_o), 8'h42);

        // Three drops while full and stalled
        drop_n(1);
        chk("drop1_cnt", int'(drop_cnt_o), 1);
        drop_n(2);
        chk("drop3_cnt", int'(drop_cnt_o), 3);
        chk("drop3_level", int'(level_o), 16);

        for (int i = 0; i < 16; i++) exp_q.push_back(8'h42 + 8'(i));
`ifdef CDC_IN_EVENT_FIFO_OVF_MARK_EN
        exp_q.push_back(8'h21);
`endif
        in_ready_i = 1'b1;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            #1;
            chk("drain_valid", int'(in_valid_o), 1);
            chk("drain_data", int'(in_data_o), int'(b));
            step();
        end
        #1;
        chk("drain_empty_valid", int'(in_valid_o), 0);
        chk("drain_empty_level", int'(level_o), 0);
        chk("drain_drop_hold", int'(drop_cnt_o), 3);

        // Unconfigure with 5 bytes queued
        in_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ev_valid_i = 1'b1;
            ev_data_i  = 8'h30 + 8'(i);
            step();
        end
        idle_inputs();
        chk("uncfg_pre_level", int'(level_o), 5);
        usb_configured_i = 1'b0;
        ev_valid_i = 1'b1;
        ev_data_i  = 8'h77;
        #1;
        chk("uncfg_ev_ready", int'(ev_ready_o), 0);
        step();
        chk("uncfg_level", int'(level_o), 0);
        chk("uncfg_valid", int'(in_valid_o), 0);
        usb_configured_i = 1'b1;
        idle_inputs();
        step();
        chk("uncfg_after_level", int'(level_o), 0);
        chk("uncfg_drop_hold", int'(drop_cnt_o), 3);

        // Reset mid-transfer with drop count 7
        fill16(8'h01);
        drop_n(4);
        chk("prereset_drop", int'(drop_cnt_o), 7);
        chk("prereset_valid", int'(in_valid_o), 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("midreset_valid", int'(in_valid_o), 0);
        chk("midreset_level", int'(level_o), 0);
        chk("midreset_drop", int'(drop_cnt_o), 0);

        // Saturation of the drop counter
        fill16(8'h80);
        drop_n(300);
        chk("sat_drop", int'(drop_cnt_o), 255);
        chk("sat_level", int'(level_o), 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
